// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
//   XLEN        : operand/result width
//   CNT_W       : width of the iteration counter
//   div_op_e    : funct3 encodings of the divide/remainder ops
//   div_state_e : sequencer FSM states
//   DIV_MIN_INT : most negative signed value (signed-overflow operand/result)
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_DIV  = 3'b100,
    OP_DIVU = 3'b101,
    OP_REM  = 3'b110,
    OP_REMU = 3'b111
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam logic [XLEN-1:0] DIV_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage <-> divider handshake.
//   master : pipeline side, drives start/funct3/rs1/rs2/flush, sees stall/done/result
//   slave  : divider side
interface div_sequencer_if;
  import riscv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, rs1, rs2, flush,
                  input  stall, done, result);

  modport slave  (input  start, funct3, rs1, rs2, flush,
                  output stall, done, result);

endinterface

// File: rtl/div_step.sv
// One combinational restoring-divide iteration.
//   rem, quo, divisor : current partial remainder, quotient/dividend shift reg, divisor
//   rem_next, quo_next: values after shifting in one dividend bit and a trial subtract
module div_step
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Shifted remainder needs XLEN+1 bits; trial's MSB is the borrow (negative).
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], ~trial[XLEN]};
  end

endmodule

// File: rtl/div_sequencer.sv
// Iterative RV32M DIV/DIVU/REM/REMU controller with pipeline stall.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : div_sequencer_if.slave (start/funct3/rs1/rs2/flush in,
//                stall (combinational), done (1-cycle pulse), result out)
module div_sequencer
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  div_sequencer_if.slave    bus
);

  div_state_e        state;
  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   divisor;
  logic              q_neg;
  logic              r_neg;
  logic              is_rem;
  logic              done;
  logic [XLEN-1:0]   result;

  logic              accept;
  logic              op_signed;
  logic              op_rem;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div_zero;
  logic              overflow;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;

  // Operand decode; unlisted funct3 codes fall through as DIVU.
  always_comb begin
    accept    = (state == ST_IDLE) && bus.start && !bus.flush;
    op_signed = (bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM);
    op_rem    = (bus.funct3 == OP_REM) || (bus.funct3 == OP_REMU);
    a_neg     = op_signed && bus.rs1[XLEN-1];
    b_neg     = op_signed && bus.rs2[XLEN-1];
    abs_a     = a_neg ? -bus.rs1 : bus.rs1;
    abs_b     = b_neg ? -bus.rs2 : bus.rs2;
    div_zero  = (bus.rs2 == '0);
    overflow  = op_signed && (bus.rs1 == DIV_MIN_INT) && (bus.rs2 == '1);
  end

  div_step u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Stall includes the arrival cycle so the op is held before it is latched.
  assign bus.stall  = accept || (state == ST_CALC) || (state == ST_FIX);
  assign bus.done   = done;
  assign bus.result = result;

  // FSM, datapath and registered outputs; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      is_rem  <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (bus.flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              is_rem <= op_rem;
              if (div_zero) begin
                result <= op_rem ? bus.rs1 : '1;
                done   <= 1'b1;
                state  <= ST_DONE;
              end else if (overflow) begin
                result <= op_rem ? '0 : DIV_MIN_INT;
                done   <= 1'b1;
                state  <= ST_DONE;
              end else begin
                rem     <= '0;
                quo     <= abs_a;
                divisor <= abs_b;
                q_neg   <= a_neg ^ b_neg;
                r_neg   <= a_neg;
                count   <= CNT_W'(XLEN - 1);
                state   <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            rem <= rem_next;
            quo <= quo_next;
            if (count == '0) state <= ST_FIX;
            else             count <= count - CNT_W'(1);
          end
          ST_FIX: begin
            result <= is_rem ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
            done   <= 1'b1;
            state  <= ST_DONE;
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  div_sequencer_if bus ();

  div_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op and wait for done; lat counts cycles after the accepting edge.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit skip_wait, output int lat, output int stalls,
                       output logic acc_stall);
    if (!skip_wait) @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    #1 acc_stall = bus.stall;
    @(negedge clk);
    bus.start = 1'b0;
    lat    = 1;
    stalls = 0;
    while (!bus.done && lat < 100) begin
      if (bus.stall) stalls++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = OP_DIVU;
    bus.rs1   = 32'd0;
    bus.rs2   = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++;
    if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b want 0", bus.stall); end
    bus.start = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL reset_stall_follows_start got %b want 1", bus.stall); end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat, stalls; logic acc;
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, stalls, acc);
    checks++;
    if (bus.result !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want %h", bus.result, 32'd14); end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL divu_latency got %0d want 34", lat); end
    checks++;
    if (stalls !== 33 || acc !== 1'b1) begin
      errors++; $display("FAIL divu_stall got %0d+%b want 33+1", stalls, acc);
    end
    do_op(OP_REMU, 32'd100, 32'd7, 1'b0, lat, stalls, acc);
    checks++;
    if (bus.result !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want %h", bus.result, 32'd2); end
  endtask

  task automatic test_div_zero();
    logic [2:0]  f3 [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] a  [4] = '{32'd5, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [31:0] exp[4] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB};
    int lat, stalls; logic acc;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], 32'd0, 1'b0, lat, stalls, acc);
      checks++;
      if (bus.result !== exp[i] || lat !== 1 || stalls !== 0 || acc !== 1'b1) begin
        errors++;
        $display("FAIL div_zero_%0d got %h lat %0d stall %0d/%b want %h lat 1 stall 0/1",
                 i, bus.result, lat, stalls, acc, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int lat, stalls; logic acc;
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, stalls, acc);
    checks++;
    if (bus.result !== 32'h80000000 || lat !== 1 || stalls !== 0) begin
      errors++; $display("FAIL ovf_div got %h lat %0d stall %0d want 80000000 lat 1 stall 0", bus.result, lat, stalls);
    end
    do_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, stalls, acc);
    checks++;
    if (bus.result !== 32'h0 || lat !== 1) begin
      errors++; $display("FAIL ovf_rem got %h lat %0d want 0 lat 1", bus.result, lat);
    end
  endtask

  task automatic test_signed();
    logic [2:0]  f3 [4] = '{OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] a  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7};
    logic [31:0] b  [4] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] exp[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1};
    int lat, stalls; logic acc;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], 1'b0, lat, stalls, acc);
      checks++;
      if (bus.result !== exp[i] || lat !== 34) begin
        errors++;
        $display("FAIL signed_%0d got %h lat %0d want %h lat 34", i, bus.result, lat, exp[i]);
      end
    end
  endtask

  task automatic test_flush();
    int lat, stalls; logic acc; int seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = OP_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL flush_idle got stall %b done %b want 0 0", bus.stall, bus.done);
    end
    checks++;
    if (bus.result !== 32'd1) begin errors++; $display("FAIL flush_result_held got %h want 1", bus.result); end
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", seen_done); end
    do_op(OP_DIVU, 32'd9, 32'd3, 1'b0, lat, stalls, acc);
    checks++;
    if (bus.result !== 32'd3 || lat !== 34) begin
      errors++; $display("FAIL after_flush got %h lat %0d want 3 lat 34", bus.result, lat);
    end
  endtask

  task automatic test_reset_mid_back_to_back();
    int lat, stalls; logic acc; int seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = OP_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 32'h0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL reset_mid got done %b result %h stall %b want 0 0 0", bus.done, bus.result, bus.stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL reset_no_done got %0d pulses want 0", seen_done); end
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, stalls, acc);
    checks++;
    if (bus.result !== 32'd14 || lat !== 34) begin
      errors++; $display("FAIL b2b_first got %h lat %0d want 14 lat 34", bus.result, lat);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL b2b_done_pulse got done %b stall %b want 0 0", bus.done, bus.stall);
    end
    do_op(OP_REM, 32'hFFFFFFF9, 32'd2, 1'b1, lat, stalls, acc);
    checks++;
    if (bus.result !== 32'hFFFFFFFF || lat !== 34 || acc !== 1'b1) begin
      errors++; $display("FAIL b2b_second got %h lat %0d acc %b want ffffffff lat 34 acc 1", bus.result, lat, acc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_signed();
    test_flush();
    test_reset_mid_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
